// File: rtl/painel_comando.sv
// Front panel for the coffee machine: turns debounced button/keypad events into registered
// machine commands (power, codigo, selecao, start, refill), paced by pump and reservoir feedback.
module painel_comando #(
  parameter int         WARMUP_CYC = 5,
  parameter int         START_TMO  = 8,
  parameter int         REFILL_CYC = 4,
  parameter logic [3:0] RES_FULL   = 4'hF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       btn_power,
  input  logic       tecla_valida,
  input  logic [3:0] tecla,
  input  logic [1:0] btn_sel,
  input  logic       btn_start,
  input  logic       btn_refill,
  input  logic       bomba,
  input  logic [3:0] reservatorio,
  output logic       power,
  output logic [6:0] codigo,
  output logic [1:0] selecao,
  output logic       start,
  output logic       refill,
  output logic [2:0] painel_st
);

  localparam int MAX_A = (WARMUP_CYC > START_TMO) ? WARMUP_CYC : START_TMO;
  localparam int MAX_P = (MAX_A > REFILL_CYC) ? MAX_A : REFILL_CYC;
  localparam int CW    = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    DESL    = 3'd0,
    AQUEC   = 3'd1,
    CODIGO  = 3'd2,
    PRONTO  = 3'd3,
    SERVIR  = 3'd4,
    RECARGA = 3'd5
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [6:0]      r_acc, w_acc;
  logic [1:0]      r_ndig, w_ndig;
  logic            r_seen, w_seen;
  logic            r_power, w_power;
  logic [6:0]      r_codigo, w_codigo;
  logic [1:0]      r_selecao, w_selecao;
  logic            r_start, w_start;
  logic            r_refill, w_refill;

  logic            w_is_digit, w_enter, w_clear;
  logic [10:0]     w_acc_mul;
  logic [6:0]      w_acc_sat;

  assign w_is_digit = tecla_valida && (tecla <= 4'd9);
  assign w_enter    = tecla_valida && (tecla == 4'hA);
  assign w_clear    = tecla_valida && (tecla == 4'hB);

  // acc*10 + d needs 11 bits before clamping to the 7-bit code range.
  assign w_acc_mul  = ({4'd0, r_acc} * 11'd10) + {7'd0, tecla};
  assign w_acc_sat  = (w_acc_mul > 11'd127) ? 7'd127 : w_acc_mul[6:0];

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt + CW'(1);
    w_acc     = r_acc;
    w_ndig    = r_ndig;
    w_seen    = r_seen;
    w_power   = r_power;
    w_codigo  = r_codigo;
    w_selecao = r_selecao;
    w_start   = r_start;
    w_refill  = r_refill;

    case (r_state)
      DESL: begin
        w_cnt = '0;
        if (btn_power) begin
          w_state = AQUEC;
          w_power = 1'b1;
        end
      end
      AQUEC: begin
        if (r_cnt >= CW'(WARMUP_CYC - 1)) begin
          w_state = CODIGO;
          w_cnt   = '0;
          w_acc   = '0;
          w_ndig  = '0;
        end
      end
      CODIGO: begin
        if (w_clear) begin
          w_acc  = '0;
          w_ndig = '0;
        end else if (w_enter && (r_ndig != 2'd0)) begin
          w_codigo = r_acc;
          w_state  = PRONTO;
          w_cnt    = '0;
        end else if (w_is_digit && (r_ndig < 2'd3)) begin
          w_acc  = w_acc_sat;
          w_ndig = r_ndig + 2'd1;
        end
      end
      PRONTO: begin
        // start outranks refill, and a key in the same cycle as start is dropped
        if (btn_start) begin
          w_selecao = btn_sel;
          w_start   = 1'b1;
          w_seen    = 1'b0;
          w_state   = SERVIR;
          w_cnt     = '0;
        end else if (btn_refill) begin
          w_refill = 1'b1;
          w_state  = RECARGA;
          w_cnt    = '0;
        end else if (w_clear) begin
          w_codigo = '0;
          w_acc    = '0;
          w_ndig   = '0;
          w_state  = CODIGO;
          w_cnt    = '0;
        end
      end
      SERVIR: begin
        if (bomba) w_seen = 1'b1;
        // Timeout applies only while the pump has never been seen running.
        if ((r_seen && !bomba) ||
            (!r_seen && !bomba && (r_cnt >= CW'(START_TMO - 1)))) begin
          w_start = 1'b0;
          w_seen  = 1'b0;
          w_state = PRONTO;
          w_cnt   = '0;
        end
      end
      RECARGA: begin
        if ((reservatorio == RES_FULL) || (r_cnt >= CW'(REFILL_CYC - 1))) begin
          w_refill = 1'b0;
          w_state  = PRONTO;
          w_cnt    = '0;
        end
      end
      default: begin
        w_state   = DESL;
        w_cnt     = '0;
        w_acc     = '0;
        w_ndig    = '0;
        w_seen    = 1'b0;
        w_power   = 1'b0;
        w_codigo  = '0;
        w_selecao = '0;
        w_start   = 1'b0;
        w_refill  = 1'b0;
      end
    endcase

    // Power-off overrides whatever the state logic decided this cycle.
    if (btn_power && (r_state != DESL)) begin
      w_state   = DESL;
      w_cnt     = '0;
      w_acc     = '0;
      w_ndig    = '0;
      w_seen    = 1'b0;
      w_power   = 1'b0;
      w_codigo  = '0;
      w_selecao = '0;
      w_start   = 1'b0;
      w_refill  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= DESL;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_ndig    <= '0;
      r_seen    <= 1'b0;
      r_power   <= 1'b0;
      r_codigo  <= '0;
      r_selecao <= '0;
      r_start   <= 1'b0;
      r_refill  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_acc     <= w_acc;
      r_ndig    <= w_ndig;
      r_seen    <= w_seen;
      r_power   <= w_power;
      r_codigo  <= w_codigo;
      r_selecao <= w_selecao;
      r_start   <= w_start;
      r_refill  <= w_refill;
    end
  end

  assign power     = r_power;
  assign codigo    = r_codigo;
  assign selecao   = r_selecao;
  assign start     = r_start;
  assign refill    = r_refill;
  assign painel_st = r_state;

endmodule
